snn_readout_wta: RTL and testbench

Parametrised readout and winner-take-all stage for the spiking classifier; it is the successor to the fixed 5-channel, fixed-weight, wrapping readout/argmax.
- Integrates NUM_CH hidden-layer spike trains over a bounded inference window.
- Per-channel runtime weights, saturating accumulators and optional periodic leak.
- Sequential argmax scan.
- Result presented on a valid/ready handshake.
- Sits between the hidden LIF layer and the top-level output pins.

---
 rtl/snn_pkg.sv | 46 ++++
 rtl/readout_accum.sv | 55 +++++
 rtl/snn_readout_wta.sv | 189 ++++++++++++++++++
 tb/tb_snn_readout_wta.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking-classifier readout stage:
//   - state_e     : readout / winner-take-all controller states
//   - W_W_DEF     : default readout weight width
//   - ACC_W_DEF   : default accumulator width
//   - sat_add_sub : a + add - sub evaluated at full precision, then clamped to
//                   the unsigned range [0, 2^width-1] of the caller's width
// -----------------------------------------------------------------------------
package snn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_INTEGRATE = 2'd1,
      ST_SCAN      = 2'd2,
      ST_DONE      = 2'd3
   } state_e;

   localparam int W_W_DEF   = 8;
   localparam int ACC_W_DEF = 8;

   // Widest operand the saturating helper accepts; callers zero-extend into it
   // and cast the result back down to their own width.
   localparam int SAT_MAX_W = 32;

   function automatic logic [SAT_MAX_W-1:0] sat_add_sub(
      input logic [SAT_MAX_W-1:0] a,
      input logic [SAT_MAX_W-1:0] add,
      input logic [SAT_MAX_W-1:0] sub,
      input int unsigned          width
   );
      logic signed [SAT_MAX_W+1:0] sum;
      logic        [SAT_MAX_W:0]   lim;
      // Two guard bits: one for the carry of the add, one for the sign of the sub.
      sum = $signed({2'b00, a}) + $signed({2'b00, add}) - $signed({2'b00, sub});
      lim = ((SAT_MAX_W+1)'(1) << width) - (SAT_MAX_W+1)'(1);
      if (sum[SAT_MAX_W+1]) begin
         return '0;
      end else if (sum > $signed({1'b0, lim})) begin
         return lim[SAT_MAX_W-1:0];
      end else begin
         return sum[SAT_MAX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/readout_accum.sv
// -----------------------------------------------------------------------------
// readout_accum
// One readout channel: a saturating unsigned accumulator that adds its weight
// when the channel spikes and optionally subtracts a shifted copy of itself
// (leak) on leak ticks. The leak is computed from the pre-update value.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clear_i        zero the accumulator (takes priority over en_i)
//   en_i           integrate this cycle
//   spike_i        channel spike for this cycle
//   weight_i       channel weight (W_W bits, unsigned)
//   leak_tick_i    apply leak this cycle (ignored when LEAK_SHIFT == 0)
//   acc_o          accumulator value (ACC_W bits)
// -----------------------------------------------------------------------------
module readout_accum
   import snn_pkg::*;
#(
   parameter int W_W        = W_W_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int LEAK_SHIFT = 0
)(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             en_i,
   input  logic             spike_i,
   input  logic [W_W-1:0]   weight_i,
   input  logic             leak_tick_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] add_val, leak_val;

   always_comb begin
      add_val  = spike_i ? ACC_W'(weight_i) : '0;
      // A zero shift means "no leak", not "leak everything".
      leak_val = (LEAK_SHIFT != 0 && leak_tick_i) ? (acc_q >> LEAK_SHIFT) : '0;
      acc_d    = ACC_W'(sat_add_sub(SAT_MAX_W'(acc_q), SAT_MAX_W'(add_val),
                                    SAT_MAX_W'(leak_val), ACC_W));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else if (clear_i) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/snn_readout_wta.sv
// -----------------------------------------------------------------------------
// snn_readout_wta
// Readout + winner-take-all for the spiking classifier. On start it latches the
// per-channel weights, integrates NUM_CH spike trains for WINDOW cycles into
// saturating accumulators (with optional periodic leak), scans the channels one
// per cycle for the strict maximum (ties go to the lowest index) and presents
// the winner on a valid/ready handshake.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   start_i          begin an inference (only honoured in IDLE)
//   abort_i          cancel the current inference, back to IDLE
//   spikes_i         per-channel spikes, bit i = channel i
//   weights_i        flat weights, channel i at [i*W_W +: W_W]
//   busy_o           integrating or scanning
//   result_valid_o   result available; held until result_ready_i
//   result_ready_i   consumer accepts the result
//   winner_idx_o     index of the largest accumulator
//   winner_val_o     value of the largest accumulator
//   any_o            winner_val_o != 0
// -----------------------------------------------------------------------------
module snn_readout_wta
   import snn_pkg::*;
#(
   parameter int NUM_CH      = 5,
   parameter int W_W         = W_W_DEF,
   parameter int ACC_W       = ACC_W_DEF,
   parameter int WINDOW      = 16,
   parameter int LEAK_PERIOD = 4,
   parameter int LEAK_SHIFT  = 0,
   parameter int IDX_W       = $clog2(NUM_CH)
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic [NUM_CH-1:0]     spikes_i,
   input  logic [NUM_CH*W_W-1:0] weights_i,
   output logic                  busy_o,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [IDX_W-1:0]      winner_idx_o,
   output logic [ACC_W-1:0]      winner_val_o,
   output logic                  any_o
);

   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int LP_W  = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
   localparam logic [LP_W-1:0]  LP_LAST  = LP_W'(LEAK_PERIOD - 1);
   localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_CH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LP_W-1:0]  lp_q, lp_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d, win_idx_q, win_idx_d, cand_idx;
   logic [ACC_W-1:0] best_val_q, best_val_d, win_val_q, win_val_d, cand_val;
   logic [W_W-1:0]   w_q [NUM_CH];
   logic [ACC_W-1:0] acc [NUM_CH];
   logic             acc_clr, acc_en, leak_tick, w_load;

   // Next state, counters and argmax scan.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lp_d       = lp_q;
      ptr_d      = ptr_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      win_idx_d  = win_idx_q;
      win_val_d  = win_val_q;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;
      w_load     = 1'b0;
      // lp_q counts integration cycles modulo LEAK_PERIOD, so the tick lands on
      // the cycles where the 1-based window count is a multiple of the period.
      leak_tick  = (lp_q == LP_LAST);
      // Strict compare keeps the earlier (lower-index) channel on a tie.
      if (acc[ptr_q] > best_val_q) begin
         cand_val = acc[ptr_q];
         cand_idx = ptr_q;
      end else begin
         cand_val = best_val_q;
         cand_idx = best_idx_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i && !abort_i) begin
               acc_clr = 1'b1;
               w_load  = 1'b1;
               cnt_d   = '0;
               lp_d    = '0;
               state_d = ST_INTEGRATE;
            end
         end
         ST_INTEGRATE: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               acc_en = 1'b1;
               cnt_d  = cnt_q + CNT_W'(1);
               lp_d   = (lp_q == LP_LAST) ? '0 : lp_q + LP_W'(1);
               if (cnt_q == CNT_LAST) begin
                  ptr_d      = '0;
                  best_val_d = '0;
                  best_idx_d = '0;
                  state_d    = ST_SCAN;
               end
            end
         end
         ST_SCAN: begin
            if (abort_i) begin
               state_d = ST_IDLE;
            end else begin
               best_val_d = cand_val;
               best_idx_d = cand_idx;
               ptr_d      = ptr_q + IDX_W'(1);
               if (ptr_q == PTR_LAST) begin
                  win_val_d = cand_val;
                  win_idx_d = cand_idx;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (abort_i || result_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lp_q       <= '0;
         ptr_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         win_idx_q  <= '0;
         win_val_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lp_q       <= lp_d;
         ptr_q      <= ptr_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         win_idx_q  <= win_idx_d;
         win_val_q  <= win_val_d;
      end
   end

   // Weights are sampled once at start; later changes on weights_i are ignored.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_CH; i++) w_q[i] <= '0;
      end else if (w_load) begin
         for (int i = 0; i < NUM_CH; i++) w_q[i] <= weights_i[i*W_W +: W_W];
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      readout_accum #(
         .W_W        (W_W),
         .ACC_W      (ACC_W),
         .LEAK_SHIFT (LEAK_SHIFT)
      ) u_acc (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .clear_i     (acc_clr),
         .en_i        (acc_en),
         .spike_i     (spikes_i[g]),
         .weight_i    (w_q[g]),
         .leak_tick_i (leak_tick),
         .acc_o       (acc[g])
      );
   end

   assign busy_o         = (state_q == ST_INTEGRATE) || (state_q == ST_SCAN);
   assign result_valid_o = (state_q == ST_DONE);
   assign winner_idx_o   = win_idx_q;
   assign winner_val_o   = win_val_q;
   assign any_o          = (win_val_q != '0);

endmodule

// File: tb/tb_snn_readout_wta.sv
// -----------------------------------------------------------------------------
// tb_snn_readout_wta
// Two readout instances share one stimulus stream: u_dut0 without leak and
// u_dut1 with LEAK_SHIFT=1 / LEAK_PERIOD=4. A cycle-count model of each
// instance predicts busy/valid/winner outputs; directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_snn_readout_wta;

   localparam int NCH  = 4;
   localparam int WW   = 8;
   localparam int AW   = 8;
   localparam int WIN  = 8;
   localparam int LP   = 4;
   localparam int IW   = 2;
   localparam int LAT  = WIN + NCH;
   localparam int AMAX = (1 << AW) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic            ready = 1'b1;
   logic [NCH-1:0]  spikes = '0;
   logic [NCH*WW-1:0] weights = '0;

   logic            busy0, valid0, any0, busy1, valid1, any1;
   logic [IW-1:0]   idx0, idx1;
   logic [AW-1:0]   val0, val1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   snn_readout_wta #(.NUM_CH(NCH), .W_W(WW), .ACC_W(AW), .WINDOW(WIN),
                     .LEAK_PERIOD(LP), .LEAK_SHIFT(0)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .spikes_i(spikes), .weights_i(weights), .busy_o(busy0),
      .result_valid_o(valid0), .result_ready_i(ready),
      .winner_idx_o(idx0), .winner_val_o(val0), .any_o(any0));

   snn_readout_wta #(.NUM_CH(NCH), .W_W(WW), .ACC_W(AW), .WINDOW(WIN),
                     .LEAK_PERIOD(LP), .LEAK_SHIFT(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .spikes_i(spikes), .weights_i(weights), .busy_o(busy1),
      .result_valid_o(valid1), .result_ready_i(ready),
      .winner_idx_o(idx1), .winner_val_o(val1), .any_o(any1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An inference is "running" from the accepted start until the result is
   // accepted or aborted; m_t counts edges since the start. The window is
   // edges 1..WIN, and the result appears LAT edges after the start.
   int m_acc [2][NCH];
   int m_w   [2][NCH];
   bit m_run [2];
   int m_t   [2];
   int e_idx [2];
   int e_val [2];

   function automatic int lsh(input int k);
      return (k == 0) ? 0 : 1;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_run[k] = 1'b0; m_t[k] = 0; e_idx[k] = 0; e_val[k] = 0;
         for (int i = 0; i < NCH; i++) begin m_acc[k][i] = 0; m_w[k][i] = 0; end
      end
   endtask

   task automatic m_step(input int k);
      int v, lk, mx;
      if (!m_run[k]) begin
         if (start && !abort) begin
            m_run[k] = 1'b1;
            m_t[k]   = 0;
            for (int i = 0; i < NCH; i++) begin
               m_w[k][i]   = int'(weights[i*WW +: WW]);
               m_acc[k][i] = 0;
            end
         end
      end else if (abort) begin
         m_run[k] = 1'b0;
      end else if (m_t[k] < LAT) begin
         m_t[k]++;
         if (m_t[k] <= WIN) begin
            for (int i = 0; i < NCH; i++) begin
               lk = (lsh(k) != 0 && (m_t[k] % LP) == 0) ? (m_acc[k][i] >> lsh(k)) : 0;
               v  = m_acc[k][i] + (spikes[i] ? m_w[k][i] : 0) - lk;
               if (v < 0) v = 0;
               if (v > AMAX) v = AMAX;
               m_acc[k][i] = v;
            end
         end
         if (m_t[k] == LAT) begin
            mx = 0;
            for (int i = 0; i < NCH; i++) if (m_acc[k][i] > mx) mx = m_acc[k][i];
            for (int i = NCH - 1; i >= 0; i--) if (m_acc[k][i] == mx) e_idx[k] = i;
            e_val[k] = mx;
         end
      end else if (ready) begin
         m_run[k] = 1'b0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else for (int k = 0; k < 2; k++) m_step(k);
   end

   task automatic cmp(input int k, input logic b, input logic v, input logic [IW-1:0] ix,
                      input logic [AW-1:0] vl, input logic an);
      chk($sformatf("d%0d busy", k),  32'(b),  32'(m_run[k] && m_t[k] < LAT));
      chk($sformatf("d%0d valid", k), 32'(v),  32'(m_run[k] && m_t[k] == LAT));
      chk($sformatf("d%0d idx", k),   32'(ix), e_idx[k]);
      chk($sformatf("d%0d val", k),   32'(vl), e_val[k]);
      chk($sformatf("d%0d any", k),   32'(an), 32'(e_val[k] != 0));
   endtask

   always @(posedge clk) begin
      #2;
      cmp(0, busy0, valid0, idx0, val0, any0);
      cmp(1, busy1, valid1, idx1, val1, any1);
   end

   // ---------------- stimulus helpers ----------------
   logic [NCH-1:0] spk_tab [WIN];

   task automatic set_w(input int w0, input int w1, input int w2, input int w3);
      weights = {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
   endtask

   task automatic set_tab(input logic [NCH-1:0] s);
      for (int i = 0; i < WIN; i++) spk_tab[i] = s;
   endtask

   // Called at a negedge with the DUT idle: start is sampled at E0 and
   // spk_tab[i] at edge E(i+1). Returns at the negedge after E(WIN).
   task automatic feed();
      start  = 1'b1;
      spikes = '0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < WIN; i++) begin
         spikes = spk_tab[i];
         @(negedge clk);
      end
      spikes = '0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (valid0 !== 1'b1 && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
   endtask

   task automatic idle_gap();
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      #1 rst_n = 1'b0;
      #2;
      chk("reset busy", 32'(busy0), 0);
      chk("reset valid", 32'(valid0), 0);
      chk("reset idx", 32'(idx0), 0);
      chk("reset val", 32'(val0), 0);
      chk("reset any", 32'(any0), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic argmax with saturation on channel 3.
      set_w(10, 20, 30, 40);
      set_tab(4'hF);
      feed();
      wait_valid(n);
      chk("basic latency", n, 4);
      chk("basic idx", 32'(idx0), 3);
      chk("basic val", 32'(val0), 255);
      chk("basic any", 32'(any0), 1);
      chk("model acc0", m_acc[0][0], 80);
      chk("model acc1", m_acc[0][1], 160);
      chk("model acc2", m_acc[0][2], 240);
      chk("model acc3", m_acc[0][3], 255);
      idle_gap();

      // Reset in the middle of SCAN.
      feed();
      @(posedge clk); @(posedge clk); #2;
      chk("midscan busy", 32'(busy0), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("async rst busy", 32'(busy0), 0);
      chk("async rst idx", 32'(idx0), 0);
      chk("async rst val", 32'(val0), 0);
      chk("async rst any", 32'(any0), 0);
      chk("async rst valid1", 32'(valid1), 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-pressure: result held while ready is low, start in DONE ignored.
      ready = 1'b0;
      set_w(9, 3, 40, 40);
      spk_tab[0] = 4'h5; spk_tab[1] = 4'h5; spk_tab[2] = 4'h5; spk_tab[3] = 4'h3;
      spk_tab[4] = 4'h1; spk_tab[5] = 4'h9; spk_tab[6] = 4'h9; spk_tab[7] = 4'h9;
      feed();
      wait_valid(n);
      chk("bp latency", n, 4);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         start = (c == 2);
         @(posedge clk); #2;
         chk("bp valid", 32'(valid0), 1);
         chk("bp idx", 32'(idx0), 2);
         chk("bp val", 32'(val0), 120);
         chk("bp busy", 32'(busy0), 0);
      end
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      @(posedge clk); #2;
      chk("accept valid", 32'(valid0), 0);
      chk("accept idx hold", 32'(idx0), 2);
      idle_gap();

      // Tie-break: fresh inference after the accept.
      set_w(50, 50, 0, 0);
      set_tab(4'h0);
      spk_tab[0] = 4'h3; spk_tab[1] = 4'h3;
      feed();
      wait_valid(n);
      chk("tie latency", n, 4);
      chk("tie idx", 32'(idx0), 0);
      chk("tie val", 32'(val0), 100);
      chk("tie leak idx", 32'(idx1), 0);
      chk("tie leak val", 32'(val1), 25);
      idle_gap();

      // Leak: single spike of 64 halves at E4 and E8.
      set_w(64, 0, 0, 0);
      set_tab(4'h0);
      spk_tab[0] = 4'h1;
      feed();
      wait_valid(n);
      chk("leak idx", 32'(idx1), 0);
      chk("leak val", 32'(val1), 16);
      chk("leak model acc", m_acc[1][0], 16);
      chk("noleak val", 32'(val0), 64);
      idle_gap();

      // No spikes in the whole window.
      set_w(200, 200, 200, 200);
      set_tab(4'h0);
      feed();
      wait_valid(n);
      chk("zero valid", 32'(valid0), 1);
      chk("zero idx", 32'(idx0), 0);
      chk("zero val", 32'(val0), 0);
      chk("zero any", 32'(any0), 0);
      chk("zero valid1", 32'(valid1), 1);
      idle_gap();

      // Abort sampled at E3.
      set_w(10, 20, 30, 40);
      start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      spikes = 4'hF;
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #2;
      chk("abort busy", 32'(busy0), 0);
      chk("abort busy1", 32'(busy1), 0);
      chk("abort valid", 32'(valid0), 0);
      @(negedge clk);
      abort  = 1'b0;
      spikes = '0;
      n = 0;
      repeat (LAT + 4) begin
         @(posedge clk); #2;
         if (valid0 === 1'b1 || busy0 === 1'b1) n++;
      end
      chk("abort no result", n, 0);

      // Abort together with start in IDLE: nothing starts.
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); #2;
      chk("abort+start busy", 32'(busy0), 0);
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      @(posedge clk); #2;
      chk("abort+start idle", 32'(busy0), 0);
      idle_gap();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
